// File: rtl/rom_loader.sv
// Framed byte-stream loader for the 24-bit instruction ROM.
// Assembles SYNC/LEN/payload/CSUM frames into ROM writes and holds the CPU while loading.
module rom_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         ADDR_W    = 11,
  parameter int         TIMEOUT   = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              rom_w_enable,
  output logic [ADDR_W-1:0] rom_w_addr,
  output logic [23:0]       rom_w_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        lenHi_q, lenHi_d;
  logic [ADDR_W-1:0] lastIdx_q, lastIdx_d;
  logic [ADDR_W-1:0] wordIdx_q, wordIdx_d;
  logic [1:0]        byteIdx_q, byteIdx_d;
  logic [15:0]       asm_q, asm_d;
  logic [7:0]        sum_q, sum_d;
  logic [CNT_W-1:0]  idleCnt_q, idleCnt_d;
  logic              wrEn_q, wrEn_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [23:0]       wrData_q, wrData_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;
  logic              timedOut;

  assign rx_ready     = 1'b1;
  assign accept       = rx_valid;
  assign rom_w_enable = wrEn_q;
  assign rom_w_addr   = wrAddr_q;
  assign rom_w_data   = wrData_q;
  assign cpu_hold     = hold_q;
  assign load_done    = done_q;
  assign load_error   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lenHi_q   <= '0;
      lastIdx_q <= '0;
      wordIdx_q <= '0;
      byteIdx_q <= '0;
      asm_q     <= '0;
      sum_q     <= '0;
      idleCnt_q <= '0;
      wrEn_q    <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lenHi_q   <= lenHi_d;
      lastIdx_q <= lastIdx_d;
      wordIdx_q <= wordIdx_d;
      byteIdx_q <= byteIdx_d;
      asm_q     <= asm_d;
      sum_q     <= sum_d;
      idleCnt_q <= idleCnt_d;
      wrEn_q    <= wrEn_d;
      wrAddr_q  <= wrAddr_d;
      wrData_q  <= wrData_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lenHi_d   = lenHi_q;
    lastIdx_d = lastIdx_q;
    wordIdx_d = wordIdx_q;
    byteIdx_d = byteIdx_q;
    asm_d     = asm_q;
    sum_d     = sum_q;
    idleCnt_d = '0;
    wrEn_d    = 1'b0;
    wrAddr_d  = wrAddr_q;
    wrData_d  = wrData_q;
    hold_d    = hold_q;
    done_d    = done_q;
    err_d     = err_q;
    timedOut  = 1'b0;

    // Inter-byte watchdog, only armed while a frame is open.
    if (state_q != S_IDLE && !accept) begin
      idleCnt_d = idleCnt_q + CNT_W'(1);
      timedOut  = (idleCnt_q == CNT_W'(TIMEOUT - 1));
    end

    case (state_q)
      S_IDLE: begin
        if (accept && rx_data == SYNC_BYTE) begin
          state_d   = S_LEN_HI;
          hold_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          wordIdx_d = '0;
          sum_d     = '0;
          byteIdx_d = '0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          if (rx_data[7:3] != 5'd0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            lenHi_d = rx_data[2:0];
            state_d = S_LEN_LO;
          end
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          lastIdx_d = ADDR_W'({lenHi_q, rx_data});
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          sum_d = sum_q + rx_data;
          if (byteIdx_q == 2'd2) begin
            wrEn_d    = 1'b1;
            wrAddr_d  = wordIdx_q;
            wrData_d  = {asm_q, rx_data};
            byteIdx_d = '0;
            // The last word stops the index here so it never wraps past 2047.
            if (wordIdx_q == lastIdx_q) begin
              state_d = S_CSUM;
            end else begin
              wordIdx_d = wordIdx_q + ADDR_W'(1);
            end
          end else begin
            asm_d     = {asm_q[7:0], rx_data};
            byteIdx_d = byteIdx_q + 2'd1;
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = S_IDLE;
          if (rx_data == sum_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timedOut) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end
  end

endmodule
